// File: rtl/esd_multi_channel_ctrl.sv
// ---------------------------------------------------------------------------
// esd_multi_channel_ctrl
//
// Emergency-shutdown controller for N_ESTOP active-low E-STOP channels plus a
// kick-style watchdog. Any active channel or an expired watchdog trips the
// plant to the de-energised state. The causes are latched in fault_cause until
// an operator ACK (press and release) re-arms with every cause cleared.
//
// Ports:
//   clk          in   single rising-edge clock
//   rst          in   synchronous active-high reset
//   estop_n      in   [N_ESTOP] async E-STOP inputs, active low
//   ack_n        in   async ACK button, active low
//   wdg_kick     in   async watchdog kick, rising edge counts
//   async_in     in   general async input
//   shutdown     out  1 = plant de-energised (state != RUN)
//   led          out  status LED (solid in SAFE, slow blink RUN, fast blink TRIP)
//   state        out  [2] 00 SAFE, 01 RUN, 10 TRIP
//   fault_cause  out  [N_ESTOP+1] bit i = channel i, top bit = watchdog
//   wdg_expired  out  watchdog expired flag
//   sync_out     out  async_in after SYNC_STAGES flops
//
// Handshakes: this block has no valid/ready interfaces; every input is a
// level or edge sampled through its own synchronizer.
// ---------------------------------------------------------------------------
module esd_multi_channel_ctrl #(
    parameter int N_ESTOP            = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int WDG_TIMEOUT_CYCLES = 25000000,
    parameter int BLINK_HALF_CYCLES  = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ESTOP-1:0] estop_n,
    input  logic               ack_n,
    input  logic               wdg_kick,
    input  logic               async_in,
    output logic               shutdown,
    output logic               led,
    output logic [1:0]         state,
    output logic [N_ESTOP:0]   fault_cause,
    output logic               wdg_expired,
    output logic               sync_out
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WDG_W = $clog2(WDG_TIMEOUT_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF_CYCLES + 1);

    localparam logic [1:0] ST_SAFE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_TRIP = 2'b10;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WDG_W-1:0] WDG_MAX   = WDG_W'(WDG_TIMEOUT_CYCLES);
    localparam logic [BLK_W-1:0] RUN_LAST  = BLK_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [BLK_W-1:0] TRIP_LAST = BLK_W'(BLINK_HALF_CYCLES / 4 - 1);

    // Synchronizer chains; index SYNC_STAGES-1 is the synchronized value.
    logic [N_ESTOP-1:0]     estop_sync_q [SYNC_STAGES];
    logic [N_ESTOP-1:0]     estop_sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ack_sync_q,   ack_sync_d;
    logic [SYNC_STAGES-1:0] kick_sync_q,  kick_sync_d;
    logic [SYNC_STAGES-1:0] async_sync_q, async_sync_d;

    // E-STOP release debounce: est_rel_q[i] = channel i debounced released.
    logic [N_ESTOP-1:0] est_rel_q, est_rel_d;
    logic [DEB_W-1:0]   est_cnt_q [N_ESTOP];
    logic [DEB_W-1:0]   est_cnt_d [N_ESTOP];

    logic               ack_db_q,   ack_db_d;
    logic               ack_prev_q, ack_prev_d;
    logic [DEB_W-1:0]   ack_cnt_q,  ack_cnt_d;

    logic               kick_prev_q, kick_prev_d;
    logic [WDG_W-1:0]   wdg_cnt_q,   wdg_cnt_d;
    logic               wdg_exp_q,   wdg_exp_d;

    logic [1:0]         state_q, state_d;
    logic [N_ESTOP:0]   fault_q, fault_d;
    logic               led_q,   led_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;

    logic [N_ESTOP-1:0] estop_s;
    logic               ack_s, kick_s, kick_edge, ack_event;
    logic [N_ESTOP-1:0] chan_active;
    logic               estop_clear;
    logic [N_ESTOP:0]   causes;

    always_comb begin
        estop_sync_d[0] = estop_n;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            estop_sync_d[s] = estop_sync_q[s-1];
        end
        ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], ack_n};
        kick_sync_d  = {kick_sync_q[SYNC_STAGES-2:0], wdg_kick};
        async_sync_d = {async_sync_q[SYNC_STAGES-2:0], async_in};

        estop_s = estop_sync_q[SYNC_STAGES-1];
        ack_s   = ack_sync_q[SYNC_STAGES-1];
        kick_s  = kick_sync_q[SYNC_STAGES-1];

        // A synchronized low is active at once; only the release is debounced.
        est_rel_d = est_rel_q;
        est_cnt_d = est_cnt_q;
        for (int i = 0; i < N_ESTOP; i++) begin
            if (!estop_s[i]) begin
                est_rel_d[i] = 1'b0;
                est_cnt_d[i] = '0;
            end else if (!est_rel_q[i]) begin
                if (est_cnt_q[i] == DEB_LAST) begin
                    est_rel_d[i] = 1'b1;
                    est_cnt_d[i] = '0;
                end else begin
                    est_cnt_d[i] = est_cnt_q[i] + 1'b1;
                end
            end
        end
        chan_active = ~estop_s | ~est_rel_q;
        estop_clear = ~|chan_active;

        // ACK debounced both ways; the event is the debounced release edge.
        ack_db_d  = ack_db_q;
        ack_cnt_d = '0;
        if (ack_s != ack_db_q) begin
            if (ack_cnt_q == DEB_LAST) begin
                ack_db_d = ack_s;
            end else begin
                ack_cnt_d = ack_cnt_q + 1'b1;
            end
        end
        ack_prev_d = ack_db_q;
        ack_event  = ack_db_q & ~ack_prev_q;

        // Watchdog: a kick edge takes priority over reaching the timeout.
        kick_prev_d = kick_s;
        kick_edge   = kick_s & ~kick_prev_q;
        wdg_cnt_d   = wdg_cnt_q;
        wdg_exp_d   = wdg_exp_q;
        if (kick_edge) begin
            wdg_cnt_d = '0;
            wdg_exp_d = 1'b0;
        end else begin
            if (wdg_cnt_q != WDG_MAX) begin
                wdg_cnt_d = wdg_cnt_q + 1'b1;
            end
            if (wdg_cnt_d == WDG_MAX) begin
                wdg_exp_d = 1'b1;
            end
        end

        causes  = {wdg_exp_q, chan_active};
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            ST_SAFE, ST_TRIP: begin
                if (ack_event && estop_clear && !wdg_exp_q) begin
                    state_d = ST_RUN;
                    fault_d = '0;
                end else if (state_q == ST_TRIP) begin
                    fault_d = fault_q | causes;
                end
            end
            ST_RUN: begin
                if (|causes) begin
                    state_d = ST_TRIP;
                    // Capture the cause on entry so a one-cycle trip is not lost.
                    fault_d = fault_q | causes;
                end
            end
            default: state_d = ST_SAFE;
        endcase

        led_d     = led_q;
        blk_cnt_d = '0;
        if (state_d != state_q) begin
            led_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (blk_cnt_q == RUN_LAST) led_d = ~led_q;
                    else blk_cnt_d = blk_cnt_q + 1'b1;
                end
                ST_TRIP: begin
                    if (blk_cnt_q == TRIP_LAST) led_d = ~led_q;
                    else blk_cnt_d = blk_cnt_q + 1'b1;
                end
                default: led_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                estop_sync_q[s] <= '0;
            end
            ack_sync_q   <= '1;
            kick_sync_q  <= '0;
            async_sync_q <= '0;
            est_rel_q    <= '0;
            for (int i = 0; i < N_ESTOP; i++) begin
                est_cnt_q[i] <= '0;
            end
            ack_db_q    <= 1'b1;
            ack_prev_q  <= 1'b1;
            ack_cnt_q   <= '0;
            kick_prev_q <= 1'b0;
            wdg_cnt_q   <= '0;
            wdg_exp_q   <= 1'b0;
            state_q     <= ST_SAFE;
            fault_q     <= '0;
            led_q       <= 1'b1;
            blk_cnt_q   <= '0;
        end else begin
            estop_sync_q <= estop_sync_d;
            ack_sync_q   <= ack_sync_d;
            kick_sync_q  <= kick_sync_d;
            async_sync_q <= async_sync_d;
            est_rel_q    <= est_rel_d;
            est_cnt_q    <= est_cnt_d;
            ack_db_q     <= ack_db_d;
            ack_prev_q   <= ack_prev_d;
            ack_cnt_q    <= ack_cnt_d;
            kick_prev_q  <= kick_prev_d;
            wdg_cnt_q    <= wdg_cnt_d;
            wdg_exp_q    <= wdg_exp_d;
            state_q      <= state_d;
            fault_q      <= fault_d;
            led_q        <= led_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign shutdown    = (state_q != ST_RUN);
    assign led         = led_q;
    assign state       = state_q;
    assign fault_cause = fault_q;
    assign wdg_expired = wdg_exp_q;
    assign sync_out    = async_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_esd_multi_channel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_esd_multi_channel_ctrl
//
// Directed bench for esd_multi_channel_ctrl with N_ESTOP=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, WDG_TIMEOUT_CYCLES=200, BLINK_HALF_CYCLES=16. Inputs are
// driven 1 time unit after a rising edge and outputs are sampled at the same
// point, so "after edge k" below means the sample taken just after edge k.
// ---------------------------------------------------------------------------
module tb_esd_multi_channel_ctrl;

    localparam logic [1:0] ST_SAFE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_TRIP = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] estop_n;
    logic       ack_n;
    logic       wdg_kick;
    logic       async_in;
    logic       shutdown;
    logic       led;
    logic [1:0] state;
    logic [4:0] fault_cause;
    logic       wdg_expired;
    logic       sync_out;

    logic kick_auto = 1'b0;
    logic kick_man  = 1'b0;
    logic kick_en   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    assign wdg_kick = kick_auto | kick_man;

    esd_multi_channel_ctrl #(
        .N_ESTOP           (4),
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (8),
        .WDG_TIMEOUT_CYCLES(200),
        .BLINK_HALF_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .estop_n    (estop_n),
        .ack_n      (ack_n),
        .wdg_kick   (wdg_kick),
        .async_in   (async_in),
        .shutdown   (shutdown),
        .led        (led),
        .state      (state),
        .fault_cause(fault_cause),
        .wdg_expired(wdg_expired),
        .sync_out   (sync_out)
    );

    // ---------------- clock / background kicker ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (50) @(posedge clk);
            if (kick_en) begin
                #1 kick_auto = 1'b1;
                repeat (2) @(posedge clk);
                #1 kick_auto = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_ack(input int hold);
        ack_n = 1'b0;
        tick(hold);
        ack_n = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (state === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; estop_n = 4'hF; ack_n = 1'b1; async_in = 1'b0;
        tick(3);
        n_cmp++; if (state !== ST_SAFE) begin n_err++; $display("FAIL reset_state got %b want %b", state, ST_SAFE); end
        n_cmp++; if (shutdown !== 1'b1) begin n_err++; $display("FAIL reset_shutdown got %b want 1", shutdown); end
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL reset_led got %b want 1", led); end
        n_cmp++; if (fault_cause !== 5'b0) begin n_err++; $display("FAIL reset_fault got %b want 00000", fault_cause); end
        n_cmp++; if (wdg_expired !== 1'b0) begin n_err++; $display("FAIL reset_wdg got %b want 0", wdg_expired); end
        n_cmp++; if (sync_out !== 1'b0) begin n_err++; $display("FAIL reset_sync got %b want 0", sync_out); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        bit ok;
        kick_en = 1'b1;
        press_ack(20);
        n_cmp++; if (shutdown !== 1'b1) begin n_err++; $display("FAIL startup_hold_shutdown got %b want 1", shutdown); end
        wait_state(ST_RUN, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL startup_run got state %b want %b", state, ST_RUN); end
        n_cmp++; if (shutdown !== 1'b0) begin n_err++; $display("FAIL startup_shutdown got %b want 0", shutdown); end
        // Entry sets led=1; it toggles after 16 more edges and again 16 later.
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL run_led_entry got %b want 1", led); end
        tick(15);
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL run_led_15 got %b want 1", led); end
        tick(1);
        n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL run_led_16 got %b want 0", led); end
        tick(16);
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL run_led_32 got %b want 1", led); end
    endtask

    task automatic test_single_trip();
        bit ok;
        estop_n[2] = 1'b0;          // first sampled at edge k
        tick(2);                    // after edge k+1
        n_cmp++; if (state !== ST_RUN) begin n_err++; $display("FAIL trip_early got %b want %b", state, ST_RUN); end
        tick(1);                    // after edge k+2
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL trip_latency got %b want %b", state, ST_TRIP); end
        n_cmp++; if (shutdown !== 1'b1) begin n_err++; $display("FAIL trip_shutdown got %b want 1", shutdown); end
        n_cmp++; if (fault_cause !== 5'b00100) begin n_err++; $display("FAIL trip_fault got %b want 00100", fault_cause); end
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL trip_led_entry got %b want 1", led); end
        tick(3);
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL trip_led_3 got %b want 1", led); end
        tick(1);
        n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL trip_led_4 got %b want 0", led); end
        tick(4);
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL trip_led_8 got %b want 1", led); end
        estop_n[2] = 1'b1;
        tick(12);
        press_ack(10);
        wait_state(ST_RUN, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL trip_rearm got state %b want %b", state, ST_RUN); end
        n_cmp++; if (fault_cause !== 5'b0) begin n_err++; $display("FAIL trip_rearm_fault got %b want 00000", fault_cause); end
    endtask

    task automatic test_debounce();
        bit ok;
        estop_n[0] = 1'b0;
        tick(4);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL deb_trip got %b want %b", state, ST_TRIP); end
        ack_n = 1'b0;
        tick(8);
        estop_n[0] = 1'b1;
        tick(4);
        // ACK release now: its event lands before the restarted channel count ends.
        ack_n = 1'b1;
        tick(1);
        estop_n[0] = 1'b0;          // one-cycle glitch restarts the release count
        tick(1);
        estop_n[0] = 1'b1;
        tick(12);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL deb_early_ack got %b want %b", state, ST_TRIP); end
        press_ack(10);
        wait_state(ST_RUN, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL deb_late_ack got state %b want %b", state, ST_RUN); end
    endtask

    task automatic test_watchdog();
        bit ok;
        kick_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (wdg_expired === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wdg_expire got %b want 1", wdg_expired); end
        n_cmp++; if (state !== ST_RUN) begin n_err++; $display("FAIL wdg_same_cycle got %b want %b", state, ST_RUN); end
        tick(1);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL wdg_trip got %b want %b", state, ST_TRIP); end
        tick(1);
        n_cmp++; if (fault_cause !== 5'b10000) begin n_err++; $display("FAIL wdg_fault got %b want 10000", fault_cause); end
        press_ack(10);
        tick(15);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL wdg_ack_nokick got %b want %b", state, ST_TRIP); end
        kick_man = 1'b1;
        tick(2);
        kick_man = 1'b0;
        tick(4);
        n_cmp++; if (wdg_expired !== 1'b0) begin n_err++; $display("FAIL wdg_kick_clear got %b want 0", wdg_expired); end
        kick_en = 1'b1;
        press_ack(10);
        wait_state(ST_RUN, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wdg_rearm got state %b want %b", state, ST_RUN); end
    endtask

    task automatic test_multi_cause();
        bit ok;
        estop_n[1] = 1'b0;
        estop_n[3] = 1'b0;
        tick(4);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL multi_trip got %b want %b", state, ST_TRIP); end
        estop_n[1] = 1'b1;
        tick(12);
        n_cmp++; if (fault_cause !== 5'b01010) begin n_err++; $display("FAIL multi_fault got %b want 01010", fault_cause); end
        press_ack(10);
        tick(15);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL multi_ack_reject got %b want %b", state, ST_TRIP); end
        estop_n[3] = 1'b1;
        tick(12);
        press_ack(10);
        wait_state(ST_RUN, 40, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_rearm got state %b want %b", state, ST_RUN); end
        n_cmp++; if (fault_cause !== 5'b0) begin n_err++; $display("FAIL multi_rearm_fault got %b want 00000", fault_cause); end
    endtask

    task automatic test_reset_mid_trip();
        estop_n[2] = 1'b0;
        tick(4);
        n_cmp++; if (state !== ST_TRIP) begin n_err++; $display("FAIL rmid_trip got %b want %b", state, ST_TRIP); end
        tick(3);                    // let the fast blink move away from 1
        rst = 1'b1;
        tick(1);
        n_cmp++; if (state !== ST_SAFE) begin n_err++; $display("FAIL rmid_state got %b want %b", state, ST_SAFE); end
        n_cmp++; if (shutdown !== 1'b1) begin n_err++; $display("FAIL rmid_shutdown got %b want 1", shutdown); end
        n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL rmid_led got %b want 1", led); end
        n_cmp++; if (fault_cause !== 5'b0) begin n_err++; $display("FAIL rmid_fault got %b want 00000", fault_cause); end
        n_cmp++; if (wdg_expired !== 1'b0) begin n_err++; $display("FAIL rmid_wdg got %b want 0", wdg_expired); end
        rst = 1'b0;
        estop_n[2] = 1'b1;
    endtask

    task automatic test_sync_out();
        async_in = 1'b1;
        tick(1);
        n_cmp++; if (sync_out !== 1'b0) begin n_err++; $display("FAIL sync_rise_1 got %b want 0", sync_out); end
        tick(1);
        n_cmp++; if (sync_out !== 1'b1) begin n_err++; $display("FAIL sync_rise_2 got %b want 1", sync_out); end
        async_in = 1'b0;
        tick(1);
        n_cmp++; if (sync_out !== 1'b1) begin n_err++; $display("FAIL sync_fall_1 got %b want 1", sync_out); end
        tick(1);
        n_cmp++; if (sync_out !== 1'b0) begin n_err++; $display("FAIL sync_fall_2 got %b want 0", sync_out); end
    endtask

    task automatic test_kick_vs_expiry();
        kick_en = 1'b0;
        tick(10);
        // First kick raised after edge p: sampled p+1, counter cleared at e=p+3.
        kick_man = 1'b1;
        tick(2);
        kick_man = 1'b0;
        tick(198);
        // Second kick sampled at p+201 -> edge seen at p+203 = e+200, the expiry edge.
        kick_man = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            n_cmp++; if (wdg_expired !== 1'b0) begin n_err++; $display("FAIL kick_wins_%0d got %b want 0", i, wdg_expired); end
        end
        kick_man = 1'b0;
        // Counter restarted at edge c=p+203; now after c+3. Expiry at c+200.
        tick(196);
        n_cmp++; if (wdg_expired !== 1'b0) begin n_err++; $display("FAIL wdg_count_199 got %b want 0", wdg_expired); end
        tick(1);
        n_cmp++; if (wdg_expired !== 1'b1) begin n_err++; $display("FAIL wdg_count_200 got %b want 1", wdg_expired); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_startup();
        test_single_trip();
        test_debounce();
        test_watchdog();
        test_multi_cause();
        test_reset_mid_trip();
        test_sync_out();
        test_kick_vs_expiry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/esd_multi_channel_ctrl.md
# esd_multi_channel_ctrl

Parametrised emergency-shutdown controller for N independent active-low E-STOP channels plus a kick-style watchdog. It trips fail-safe on any channel or on watchdog expiry and latches which causes occurred. Re-arm requires an operator ACK press-and-release with every cause cleared. It is the next-generation replacement for the fixed two-channel ESD controller and drives the plant shutdown line and the status LED.

## Interface
Parameters:
- `N_ESTOP`, default 4: number of E-STOP channels (1..16).
- `SYNC_STAGES`, default 2: synchronizer depth on every async input (>=2).
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required to accept an ACK change or an E-STOP release.
- `WDG_TIMEOUT_CYCLES`, default 25000000: cycles without a kick before expiry (500 ms at 50 MHz).
- `BLINK_HALF_CYCLES`, default 12500000: LED half-period in RUN. Must be a multiple of 4 and at least 4.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `estop_n`, in, N_ESTOP: asynchronous E-STOP inputs, active low.
- `ack_n`, in, 1: asynchronous ACK button, active low.
- `wdg_kick`, in, 1: asynchronous watchdog kick; the rising edge counts.
- `async_in`, in, 1: general asynchronous input.
- `shutdown`, out, 1: 1 = plant de-energised.
- `led`, out, 1: status LED.
- `state`, out, 2: 00 SAFE, 01 RUN, 10 TRIP.
- `fault_cause`, out, N_ESTOP+1: bit i = channel i tripped; bit N_ESTOP = watchdog tripped.
- `wdg_expired`, out, 1: watchdog expired flag.
- `sync_out`, out, 1: `async_in` after SYNC_STAGES flops.

## Operation
- **Synchronizers.** Every async input passes through SYNC_STAGES flops. Reset values are the safe values: `estop_n` 0 (pressed), `ack_n` 1, `wdg_kick` 0, `async_in` 0.
- **E-STOP debounce is asymmetric.** A synchronized low makes the channel active immediately. A return to released needs DEBOUNCE_CYCLES consecutive synchronized-high cycles. A low during that count restarts it.
- **ACK debounce.** The ACK is debounced in both directions. The ACK event is the debounced 0->1 edge (release after a press). The debounced ACK resets to 1.
- **`estop_clear`** is 1 only when all debounced channels are released.
- **Watchdog.** A saturating counter increments in all states. A synchronized `wdg_kick` rising edge clears both the counter and `wdg_expired`. `wdg_expired` sets when the count reaches WDG_TIMEOUT_CYCLES. If a kick and expiry land in the same cycle, the kick wins.
- **FSM transitions:**
  - Reset puts the FSM in SAFE.
  - SAFE or TRIP -> RUN on an ACK event when `estop_clear` is 1 and `wdg_expired` is 0. Otherwise the ACK is discarded; it is not remembered.
  - RUN -> TRIP when any channel is active or `wdg_expired` is 1.
  - ACK is ignored in RUN.
- **Fault latch.** In TRIP, `fault_cause` ORs in every active cause each cycle, so multiple causes accumulate. It clears to 0 on the RUN transition. It is never cleared in SAFE.
- **Outputs:**
  - `shutdown` = (state != RUN), decoded from the state register.
  - LED in SAFE: solid 1.
  - LED in RUN: toggles every BLINK_HALF_CYCLES.
  - LED in TRIP: toggles every BLINK_HALF_CYCLES/4.
  - Every state change sets `led` to 1 and clears the blink counter.

## Timing
- **Reset values:** `state`=00, `shutdown`=1, `led`=1, `fault_cause`=0, `wdg_expired`=0, `sync_out`=0. The watchdog, debounce and blink counters are 0.
- **After reset, E-STOP channels read active** until SYNC_STAGES+DEBOUNCE_CYCLES cycles of released input have elapsed. An ACK before then is discarded.
- **Trip latency.** `estop_n` is first sampled low at edge k; state = TRIP and `shutdown` = 1 after edge k+SYNC_STAGES. Watchdog trip happens on the edge after `wdg_expired` rises.
- **Re-arm latency.** `state` = RUN one edge after the debounced ACK release. That is SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the raw `ack_n` release.
- **Simultaneous trip and ACK.** If an ACK event coincides with a channel going active, `estop_clear` is 0 and the FSM stays in SAFE or TRIP.
- **Reset mid-operation.** Reset in any state returns everything to the reset values on the next edge. The fault latch is lost.
- **`sync_out` latency** is exactly SYNC_STAGES edges.

## Test plan
Bench parameters: N_ESTOP=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, WDG_TIMEOUT_CYCLES=200, BLINK_HALF_CYCLES=16.

1. **Startup.** Reset, then all inputs released, kick every 50 cycles, ACK held 20 cycles then released -> `shutdown`=1 until the ACK event, then `state`=01, and `led` toggles every 16 cycles.
2. **Single-channel trip.** In RUN, drive `estop_n[2]`=0 at edge k -> `shutdown`=1 and `state`=10 after edge k+2, `fault_cause`=5'b00100, `led` toggles every 4 cycles. Release channel 2 and ACK -> RUN with `fault_cause`=0.
3. **Asymmetric debounce.** In TRIP, release `estop_n[0]` for 5 cycles, glitch low for 1 cycle, then release; ACK 6 cycles after the glitch -> ignored, stay in TRIP. An ACK 12 cycles after the glitch -> RUN.
4. **Watchdog.** In RUN, stop kicks -> `wdg_expired`=1 at count 200, then `state`=10 and `fault_cause[4]`=1. ACK without a kick is discarded. Kick, then ACK -> RUN.
5. **Multiple causes.** Press channels 1 and 3 together, then release 1 -> still TRIP, `fault_cause`=5'b01010. ACK is rejected until channel 3 is released and debounced.
6. **Reset mid-TRIP, `sync_out`, and kick-vs-expiry.**
   - Assert `rst` in TRIP -> all reset values on the next edge.
   - `async_in` pulse -> `sync_out` follows 2 edges later.
   - Kick on the expiry cycle -> `wdg_expired` stays 0.
